// File: rtl/fp_ctrl_pkg.sv
// Shared definitions for the FP control path: opcode encodings (instruction
// bits [31:25]), the multi-cycle sequencer state type and the unit selector.
package fp_ctrl_pkg;

  // Single-cycle FP ops: these never stall the pipeline.
  localparam logic [6:0] OP_FADD    = 7'b0000000;
  localparam logic [6:0] OP_FSUB    = 7'b0000100;
  localparam logic [6:0] OP_FMUL    = 7'b0001000;
  localparam logic [6:0] OP_FMINMAX = 7'b0010100;
  localparam logic [6:0] OP_FCMP    = 7'b1010000;

  // Iterative FP ops handled by the multi-cycle sequencer.
  localparam logic [6:0] OP_FSQRT   = 7'b0001011;
  localparam logic [6:0] OP_FDIV    = 7'b0000011;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    WB    = 2'd3
  } mc_state_t;

  typedef enum logic {
    UNIT_SQRT = 1'b0,
    UNIT_DIV  = 1'b1
  } mc_unit_t;

  function automatic logic is_mc_op(input logic [6:0] opcode);
    return (opcode == OP_FSQRT) || (opcode == OP_FDIV);
  endfunction

endpackage

// File: rtl/fp_mc_watchdog.sv
// Watchdog counter for the multi-cycle sequencer.
// Counts enabled cycles since the last clear and flags the cycle that is the
// TIMEOUT_CYCLES-th enabled cycle. The count saturates so it never wraps while
// the sequencer sits idle after a timeout.
//
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   clear       restart the count (asserted while the sequencer is in START)
//   enable      count this cycle (asserted while waiting for done)
//   expired     the current enabled cycle is the last one allowed
module fp_mc_watchdog #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TMO_W          = 7
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TMO_W-1:0] LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + TMO_W'(1);
    end
  end

  // count holds the number of completed wait cycles, so LAST marks the final one.
  assign expired = (count == LAST);

endmodule

// File: rtl/fp_multicycle_sequencer.sv
// Multi-cycle FP sequencer sitting behind decode.
// Detects FSQRT/FDIV, pulses the owning unit's start, stalls the front of the
// pipeline until the unit reports done, then emits a one-cycle writeback of
// the captured result. Single-cycle FP ops pass by without a stall.
//
// Optional feature: define FP_MC_WATCHDOG_EN to abort a sequence whose unit
// has not answered within TIMEOUT_CYCLES wait cycles (timeout_err pulse).
// Without it the sequencer waits indefinitely and timeout_err is tied low.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   id_valid, id_opcode, id_rd       decode-stage instruction fields
//   flush                            abort any sequence in flight
//   sqrt_start/done/result           FSQRT unit handshake
//   div_start/done/result            FDIV unit handshake
//   halt_out                         stall decode and earlier stages
//   wb_valid, wb_rd, wb_data         result writeback
//   timeout_err                      watchdog abort pulse
module fp_multicycle_sequencer
  import fp_ctrl_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TMO_W          = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [6:0]        id_opcode,
  input  logic [4:0]        id_rd,
  input  logic              flush,
  output logic              sqrt_start,
  input  logic              sqrt_done,
  input  logic [DATA_W-1:0] sqrt_result,
  output logic              div_start,
  input  logic              div_done,
  input  logic [DATA_W-1:0] div_result,
  output logic              halt_out,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              timeout_err
);

  // The watchdog counter must be able to represent TIMEOUT_CYCLES.
  if (TMO_W < $clog2(TIMEOUT_CYCLES + 1)) begin : g_tmo_w_check
    $error("TMO_W too narrow for TIMEOUT_CYCLES");
  end

  mc_state_t         state_q, next_state;
  mc_unit_t          unit_q, unit_d;
  logic              mc_op;
  logic              latch_en;
  logic              capture_en;
  logic              sel_done;
  logic [DATA_W-1:0] sel_result;

`ifdef FP_MC_WATCHDOG_EN
  logic wd_clear;
  logic wd_enable;
  logic wd_expired;
  logic tmo_fire;
`endif

  assign mc_op  = is_mc_op(id_opcode);
  assign unit_d = (id_opcode == OP_FDIV) ? UNIT_DIV : UNIT_SQRT;

  // Only the unit owning the current sequence is listened to; the other
  // unit's done is ignored in every state.
  assign sel_done   = (unit_q == UNIT_DIV) ? div_done   : sqrt_done;
  assign sel_result = (unit_q == UNIT_DIV) ? div_result : sqrt_result;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      unit_q  <= UNIT_SQRT;
      wb_rd   <= '0;
      wb_data <= '0;
    end else begin
      state_q <= next_state;
      if (latch_en) begin
        unit_q <= unit_d;
        wb_rd  <= id_rd;
      end
      if (capture_en) begin
        wb_data <= sel_result;
      end
    end
  end

  always_comb begin
    next_state = state_q;
    latch_en   = 1'b0;
    capture_en = 1'b0;
    halt_out   = 1'b0;
    sqrt_start = 1'b0;
    div_start  = 1'b0;
    wb_valid   = 1'b0;
`ifdef FP_MC_WATCHDOG_EN
    wd_clear   = 1'b0;
    wd_enable  = 1'b0;
    tmo_fire   = 1'b0;
`endif

    // A flush overrides everything: no start, no writeback, no halt.
    if (flush) begin
      next_state = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (id_valid && mc_op) begin
            latch_en   = 1'b1;
            halt_out   = 1'b1;
            next_state = START;
          end
        end
        START: begin
          halt_out   = 1'b1;
          sqrt_start = (unit_q == UNIT_SQRT);
          div_start  = (unit_q == UNIT_DIV);
`ifdef FP_MC_WATCHDOG_EN
          wd_clear   = 1'b1;
`endif
          // A unit may answer in the same cycle it is started.
          if (sel_done) begin
            capture_en = 1'b1;
            next_state = WB;
          end else begin
            next_state = WAIT;
          end
        end
        WAIT: begin
          halt_out = 1'b1;
`ifdef FP_MC_WATCHDOG_EN
          wd_enable = 1'b1;
`endif
          if (sel_done) begin
            capture_en = 1'b1;
            next_state = WB;
`ifdef FP_MC_WATCHDOG_EN
          end else if (wd_expired) begin
            tmo_fire   = 1'b1;
            next_state = IDLE;
`endif
          end
        end
        WB: begin
          // The held instruction retires now; id_valid is not re-examined.
          wb_valid   = 1'b1;
          next_state = IDLE;
        end
        default: next_state = IDLE;
      endcase
    end
  end

`ifdef FP_MC_WATCHDOG_EN
  fp_mc_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TMO_W          (TMO_W)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  // The abort pulse lands in the IDLE cycle, when halt is already released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= tmo_fire;
    end
  end
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_fp_multicycle_sequencer.sv
// Self-checking bench for fp_multicycle_sequencer.
// Each multi-cycle transaction is described by its timing (done delay, flush
// cycle); the expected per-cycle outputs are derived from those timings.
module tb_fp_multicycle_sequencer;
  import fp_ctrl_pkg::*;

`ifdef FP_MC_WATCHDOG_EN
  localparam bit WD   = 1'b1;
  localparam int T    = 8;
  localparam int MAXD = 8;
`else
  localparam bit WD   = 1'b0;
  localparam int T    = 64;
  localparam int MAXD = 10;
`endif

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [6:0]  id_opcode;
  logic [4:0]  id_rd;
  logic        flush;
  logic        sqrt_start;
  logic        sqrt_done;
  logic [31:0] sqrt_result;
  logic        div_start;
  logic        div_done;
  logic [31:0] div_result;
  logic        halt_out;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        timeout_err;

  int total;
  int bad;

  fp_multicycle_sequencer #(
    .DATA_W         (32),
    .TIMEOUT_CYCLES (T),
    .TMO_W          (7)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_opcode   (id_opcode),
    .id_rd       (id_rd),
    .flush       (flush),
    .sqrt_start  (sqrt_start),
    .sqrt_done   (sqrt_done),
    .sqrt_result (sqrt_result),
    .div_start   (div_start),
    .div_done    (div_done),
    .div_result  (div_result),
    .halt_out    (halt_out),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0b exp=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // One multi-cycle transaction, cycle 0 = instruction presented in IDLE.
  // delay: done arrives 'delay' cycles after the start cycle (cycle 1); <0 = never.
  // f: flush cycle (<0 = none). tail: cycles run past the natural end (>=1).
  task automatic run_seq(input logic [6:0] op, input logic [4:0] rd, input logic [31:0] res,
                         input int delay, input bit spurious, input int f, input int tail);
    bit is_sqrt;
    bit timed_out;
    int natural_end;
    int done_c;
    int hend;
    int idlim;
    bit exp_start;
    bit exp_wb;
    bit exp_tmo;
    is_sqrt     = (op == OP_FSQRT);
    timed_out   = WD && (delay < 0 || delay > T);
    natural_end = timed_out ? (2 + T) : (2 + delay);
    done_c      = (delay >= 0) ? (1 + delay) : -1;
    if (f == 0) begin
      hend = -1; exp_start = 0; exp_wb = 0; exp_tmo = 0; idlim = 1;
    end else if (f > 0 && f <= natural_end) begin
      hend = f - 1; exp_start = (f > 1); exp_wb = 0; exp_tmo = 0; idlim = f;
    end else begin
      hend = natural_end - 1; exp_start = 1; exp_wb = !timed_out; exp_tmo = timed_out;
      idlim = timed_out ? natural_end : natural_end + 1;
    end
    for (int c = 0; c < natural_end + tail; c++) begin
      @(negedge clk);
      id_valid    = (c < idlim);
      id_opcode   = op;
      id_rd       = rd;
      flush       = (c == f);
      sqrt_done   = is_sqrt  ? (c == done_c) : (spurious && $urandom_range(0, 1) == 1);
      div_done    = !is_sqrt ? (c == done_c) : (spurious && $urandom_range(0, 1) == 1);
      sqrt_result = (is_sqrt && c == done_c)  ? res : $urandom;
      div_result  = (!is_sqrt && c == done_c) ? res : $urandom;
      #1;
      chk1("halt", halt_out, c <= hend);
      chk1("sqrt_start", sqrt_start, exp_start && is_sqrt && c == 1);
      chk1("div_start", div_start, exp_start && !is_sqrt && c == 1);
      chk1("wb_valid", wb_valid, exp_wb && c == natural_end);
      chk1("timeout_err", timeout_err, exp_tmo && c == natural_end);
      if (exp_wb && c == natural_end) begin
        chk32("wb_rd", {27'b0, wb_rd}, {27'b0, rd});
        chk32("wb_data", wb_data, res);
      end
    end
  endtask

  // Non-multi-cycle instruction held valid: nothing may happen.
  task automatic run_single(input logic [6:0] op, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      id_valid    = 1'b1;
      id_opcode   = op;
      id_rd       = 5'($urandom);
      flush       = 1'b0;
      sqrt_done   = ($urandom_range(0, 1) == 1);
      div_done    = ($urandom_range(0, 1) == 1);
      sqrt_result = $urandom;
      div_result  = $urandom;
      #1;
      chk1("single_halt", halt_out, 1'b0);
      chk1("single_sqrt_start", sqrt_start, 1'b0);
      chk1("single_div_start", div_start, 1'b0);
      chk1("single_wb_valid", wb_valid, 1'b0);
    end
  endtask

  initial begin
    logic [6:0] singles [5];
    logic [6:0] rop;
    total = 0;
    bad   = 0;
    singles[0] = OP_FADD; singles[1] = OP_FSUB; singles[2] = OP_FMUL;
    singles[3] = OP_FMINMAX; singles[4] = OP_FCMP;

    rst_n = 1'b0; id_valid = 1'b0; id_opcode = '0; id_rd = '0; flush = 1'b0;
    sqrt_done = 1'b0; div_done = 1'b0; sqrt_result = '0; div_result = '0;
    repeat (2) @(negedge clk);
    #1;
    chk1("rst_sqrt_start", sqrt_start, 1'b0);
    chk1("rst_div_start", div_start, 1'b0);
    chk1("rst_wb_valid", wb_valid, 1'b0);
    chk1("rst_timeout", timeout_err, 1'b0);
    chk1("rst_halt", halt_out, 1'b0);
    chk32("rst_wb_rd", {27'b0, wb_rd}, 32'd0);
    chk32("rst_wb_data", wb_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // FSQRT rd=5, done long after start.
    run_seq(OP_FSQRT, 5'd5, 32'h40000000, MAXD, 1'b0, -1, 3);
    // FADD held valid: no stall.
    run_single(OP_FADD, 4);
    // FDIV with spurious sqrt_done activity.
    run_seq(OP_FDIV, 5'd3, $urandom, 6, 1'b1, -1, 3);
    // Back-to-back FDIV then FSQRT, second accepted right after WB.
    run_seq(OP_FDIV, 5'd12, $urandom, 2, 1'b0, -1, 1);
    run_seq(OP_FSQRT, 5'd20, $urandom, 0, 1'b0, -1, 1);
    // Flush in WAIT, done two cycles later.
    run_seq(OP_FSQRT, 5'd7, $urandom, 4, 1'b0, 3, 3);
    // Flush in the detect cycle, in START and in the WB cycle.
    run_seq(OP_FDIV, 5'd1, $urandom, 3, 1'b0, 0, 3);
    run_seq(OP_FSQRT, 5'd2, $urandom, 3, 1'b0, 1, 3);
    run_seq(OP_FDIV, 5'd4, $urandom, 3, 1'b0, 5, 3);

    for (int i = 0; i < 24; i++) begin
      int d;
      int f;
      rop = ($urandom_range(0, 1) == 1) ? OP_FDIV : OP_FSQRT;
      d   = $urandom_range(0, 7);
      f   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2 + d) : -1;
      run_seq(rop, 5'($urandom), $urandom, d, 1'($urandom_range(0, 1)), f,
              $urandom_range(1, 3));
      if ($urandom_range(0, 2) == 0) begin
        run_single(singles[$urandom_range(0, 4)], 2);
      end
    end

    // Reset in the middle of a sequence.
    @(negedge clk);
    id_valid = 1'b1; id_opcode = OP_FDIV; id_rd = 5'd9; flush = 1'b0;
    sqrt_done = 1'b0; div_done = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    id_valid = 1'b0;
    #1;
    chk1("midrst_halt", halt_out, 1'b0);
    chk1("midrst_div_start", div_start, 1'b0);
    chk32("midrst_wb_rd", {27'b0, wb_rd}, 32'd0);
    chk32("midrst_wb_data", wb_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    div_done = 1'b1;
    div_result = $urandom;
    #1;
    chk1("midrst_done_wb", wb_valid, 1'b0);
    chk1("midrst_done_halt", halt_out, 1'b0);
    @(negedge clk);
    div_done = 1'b0;
    #1;
    chk1("midrst_after_wb", wb_valid, 1'b0);

`ifdef FP_MC_WATCHDOG_EN
    // Unit never answers: watchdog aborts, then a normal sequence still works.
    run_seq(OP_FSQRT, 5'd11, $urandom, -1, 1'b0, -1, 3);
    run_seq(OP_FDIV, 5'd13, $urandom, -1, 1'b1, -1, 1);
    run_seq(OP_FDIV, 5'd14, $urandom, T, 1'b0, -1, 3);
`endif

    // Sequencer still operational after the mid-sequence reset.
    run_seq(OP_FDIV, 5'd30, $urandom, 1, 1'b1, -1, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
